// File: rtl/cpu_pkg.sv
// Shared ISA constants for the 16-bit core: opcodes, branch condition codes,
// flag classes and flag bit positions.
package cpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_OV  = 3'b110;
  localparam logic [2:0] CC_UNC = 3'b111;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'b00,
    CLS_ZONLY = 2'b01,
    CLS_FULL  = 2'b11
  } flag_cls_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  function automatic flag_cls_t decode_cls(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB:                 decode_cls = CLS_FULL;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: decode_cls = CLS_ZONLY;
      default:                        decode_cls = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Evaluates a branch condition code against a {Z,V,N} flag vector.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       cond
);

  logic z, v, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    cond = 1'b0;
    case (ccc)
      CC_NE:   cond = ~z;
      CC_EQ:   cond = z;
      CC_GT:   cond = ~z & ~n;
      CC_LT:   cond = n;
      CC_GE:   cond = z | (~z & ~n);
      CC_LE:   cond = n | z;
      CC_OV:   cond = v;
      default: cond = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Z/V/N flag register plus the flag-writer class pipeline (ID/EX, EX/MEM,
// MEM/WB) consumed by the hazard unit, and branch-taken evaluation for IF/ID.
module flag_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] IF_ID_Inst,
  input  logic        stall,
  input  logic        ID_Flush,
  input  logic        ex_z,
  input  logic        ex_v,
  input  logic        ex_n,
  output logic        flag_br_checker,
  output logic        ID_EX_flag_br_checker,
  output logic        EX_MEM_flag_br_checker,
  output logic        br_true,
  output logic [2:0]  flags
);

  flag_cls_t  cls_idex_d, cls_idex_q;
  flag_cls_t  cls_exmem_q, cls_memwb_q;
  logic [2:0] flags_d, flags_q;
  logic       cond;

  // A stalled or flushed ID slot becomes a bubble; the instruction itself is held upstream.
  always_comb begin
    cls_idex_d = (stall | ID_Flush) ? CLS_NONE : decode_cls(IF_ID_Inst[15:12]);
  end

  always_comb begin
    flags_d = flags_q;
    case (cls_idex_q)
      CLS_FULL: begin
        flags_d[FLAG_Z] = ex_z;
        flags_d[FLAG_V] = ex_v;
        flags_d[FLAG_N] = ex_n;
      end
      CLS_ZONLY: flags_d[FLAG_Z] = ex_z;
      default:   flags_d = flags_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_idex_q  <= CLS_NONE;
      cls_exmem_q <= CLS_NONE;
      cls_memwb_q <= CLS_NONE;
      flags_q     <= 3'b000;
    end else begin
      cls_idex_q  <= cls_idex_d;
      cls_exmem_q <= cls_idex_q;
      cls_memwb_q <= cls_exmem_q;
      flags_q     <= flags_d;
    end
  end

  assign flag_br_checker        = (cls_idex_q  != CLS_NONE);
  assign ID_EX_flag_br_checker  = (cls_exmem_q != CLS_NONE);
  assign EX_MEM_flag_br_checker = (cls_memwb_q != CLS_NONE);
  assign flags                  = flags_q;

  // Only registered flags feed the condition; no forwarding from the ALU.
  branch_cond u_branch_cond (
    .ccc   (IF_ID_Inst[11:9]),
    .flags (flags_q),
    .cond  (cond)
  );

  assign br_true = (IF_ID_Inst[15:13] == 3'b110) & cond;

endmodule
